// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer: PPU pixel stream to double-buffered frame RAM writer.
// Bank swap with the VGA reader happens only on the vertical sync edge.
module ppu_fb_writer #(
  parameter int H_PIX     = 256,
  parameter int V_PIX     = 240,
  parameter int FRAME_PIX = H_PIX * V_PIX
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [5:0]  pix_data,
  input  logic        pix_frame_start,
  input  logic        vga_vs,
  output logic        fb_we,
  output logic [16:0] fb_waddr,
  output logic [7:0]  fb_wdata,
  output logic        rd_bank,
  output logic        frame_drop,
  output logic        sync_err
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_e;

  localparam logic [15:0] LAST = 16'(FRAME_PIX - 1);

  state_e      state_q;
  logic        wr_bank_q;
  logic        rd_bank_q;
  logic        vs_q;
  logic [15:0] pix_cnt_q;
  logic [15:0] pix_cnt_d;
  logic        fb_we_q;
  logic [16:0] fb_waddr_q;
  logic [7:0]  fb_wdata_q;
  logic        frame_drop_q;
  logic        sync_err_q;
  logic        vs_fall;
  logic        sof;

  assign vs_fall   = vs_q & ~vga_vs;
  assign sof       = pix_valid & pix_frame_start;
  assign pix_cnt_d = pix_cnt_q + 16'd1;

  // Frame FSM with registered write port, bank select and event pulses
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b1;
      vs_q         <= 1'b1;
      pix_cnt_q    <= 16'd0;
      fb_we_q      <= 1'b0;
      fb_waddr_q   <= 17'd0;
      fb_wdata_q   <= 8'd0;
      frame_drop_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      vs_q         <= vga_vs;
      fb_we_q      <= 1'b0;
      frame_drop_q <= 1'b0;
      sync_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sof) begin
            fb_we_q    <= 1'b1;
            fb_waddr_q <= {wr_bank_q, 16'd0};
            fb_wdata_q <= {2'b00, pix_data};
            pix_cnt_q  <= 16'd1;
            state_q    <= WRITE;
          end
        end
        WRITE: begin
          if (sof) begin
            sync_err_q <= 1'b1;
            fb_we_q    <= 1'b1;
            fb_waddr_q <= {wr_bank_q, 16'd0};
            fb_wdata_q <= {2'b00, pix_data};
            pix_cnt_q  <= 16'd1;
          end else if (pix_valid) begin
            fb_we_q    <= 1'b1;
            fb_waddr_q <= {wr_bank_q, pix_cnt_q};
            fb_wdata_q <= {2'b00, pix_data};
            if (pix_cnt_q == LAST) begin
              pix_cnt_q <= 16'd0;
              state_q   <= DONE;
            end else begin
              pix_cnt_q <= pix_cnt_d;
            end
          end
        end
        DONE: begin
          if (vs_fall) begin
            rd_bank_q <= wr_bank_q;
            wr_bank_q <= ~wr_bank_q;
            if (sof) begin
              fb_we_q    <= 1'b1;
              fb_waddr_q <= {~wr_bank_q, 16'd0};
              fb_wdata_q <= {2'b00, pix_data};
              pix_cnt_q  <= 16'd1;
              state_q    <= WRITE;
            end else begin
              state_q <= IDLE;
            end
          end else if (sof) begin
            frame_drop_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_waddr   = fb_waddr_q;
  assign fb_wdata   = fb_wdata_q;
  assign rd_bank    = rd_bank_q;
  assign frame_drop = frame_drop_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_ppu_fb_writer.sv
// tb_ppu_fb_writer: directed and randomized checks of ppu_fb_writer
// against a frame-level reference model, compared every cycle.
module tb_ppu_fb_writer;

  localparam int HP = 64;
  localparam int VP = 16;
  localparam int F  = HP * VP;

  logic        sysclk;
  logic        reset;
  logic        pix_valid;
  logic [5:0]  pix_data;
  logic        pix_frame_start;
  logic        vga_vs;
  logic        fb_we;
  logic [16:0] fb_waddr;
  logic [7:0]  fb_wdata;
  logic        rd_bank;
  logic        frame_drop;
  logic        sync_err;

  ppu_fb_writer #(.H_PIX(HP), .V_PIX(VP)) dut (
    .sysclk          (sysclk),
    .reset           (reset),
    .pix_valid       (pix_valid),
    .pix_data        (pix_data),
    .pix_frame_start (pix_frame_start),
    .vga_vs          (vga_vs),
    .fb_we           (fb_we),
    .fb_waddr        (fb_waddr),
    .fb_wdata        (fb_wdata),
    .rd_bank         (rd_bank),
    .frame_drop      (frame_drop),
    .sync_err        (sync_err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks;
  int failures;

  // reference model state
  bit          m_wr;
  bit          m_rd;
  bit          m_filled;
  bit          m_writing;
  bit          m_vs_prev;
  int          m_next;
  logic        e_we;
  logic [16:0] e_addr;
  logic [7:0]  e_data;
  logic        e_drop;
  logic        e_serr;

  // observed event tallies
  int          w_cnt;
  int          drop_cnt;
  int          serr_cnt;
  logic [16:0] last_addr;
  logic [16:0] first_addr;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr      = 1'b0;
    m_rd      = 1'b1;
    m_filled  = 1'b0;
    m_writing = 1'b0;
    m_vs_prev = 1'b1;
    m_next    = 0;
    e_we      = 1'b0;
    e_addr    = '0;
    e_data    = '0;
    e_drop    = 1'b0;
    e_serr    = 1'b0;
  endtask

  task automatic accept(input int idx, input logic [5:0] d);
    e_we      = 1'b1;
    e_addr    = {m_wr, 16'(idx)};
    e_data    = {2'b00, d};
    m_writing = 1'b1;
    m_next    = idx + 1;
    if (m_next == F) begin
      m_writing = 1'b0;
      m_filled  = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    check(tag,
          {3'b0, fb_we, fb_waddr, fb_wdata, rd_bank, frame_drop, sync_err},
          {3'b0, e_we, e_addr, e_data, logic'(m_rd), e_drop, e_serr});
    if (fb_we === 1'b1) begin
      if (w_cnt == 0) first_addr = fb_waddr;
      w_cnt++;
      last_addr = fb_waddr;
    end
    if (frame_drop === 1'b1) drop_cnt++;
    if (sync_err === 1'b1) serr_cnt++;
  endtask

  task automatic step(input logic v, input logic s,
                      input logic [5:0] d, input logic vs);
    bit vf;
    bit sof;
    pix_valid       = v;
    pix_frame_start = s;
    pix_data        = d;
    vga_vs          = vs;
    vf     = m_vs_prev && !vs;
    sof    = v && s;
    e_we   = 1'b0;
    e_drop = 1'b0;
    e_serr = 1'b0;
    if (m_filled) begin
      if (vf) begin
        m_rd     = m_wr;
        m_wr     = !m_wr;
        m_filled = 1'b0;
        if (sof) accept(0, d);
      end else if (sof) begin
        e_drop = 1'b1;
      end
    end else if (sof) begin
      if (m_writing) e_serr = 1'b1;
      accept(0, d);
    end else if (v && m_writing) begin
      accept(m_next, d);
    end
    m_vs_prev = vs;
    @(posedge sysclk);
    #1;
    compare_all("cycle");
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    pix_valid       = 1'($urandom);
    pix_frame_start = 1'($urandom);
    pix_data        = 6'($urandom);
    vga_vs          = 1'b1;
    model_reset();
    @(posedge sysclk);
    #1;
    compare_all("reset");
    reset = 1'b0;
  endtask

  // n valid pixels; mode 0 back-to-back idx%64, 1 gapped 1,0,0, 2 random
  task automatic send(input int n, input bit first_sof, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && i > 0) begin
        step(1'b0, 1'b0, 6'($urandom), 1'b1);
        step(1'b0, 1'($urandom), 6'($urandom), 1'b1);
      end
      if (mode == 2) begin
        while ($urandom_range(3) == 0)
          step(1'b0, 1'($urandom), 6'($urandom), 1'b1);
      end
      step(1'b1, first_sof && i == 0,
           (mode == 0) ? 6'(i % 64) : 6'($urandom), 1'b1);
    end
  endtask

  task automatic vsfall();
    step(1'b0, 1'b0, 6'd0, 1'b1);
    step(1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    w_cnt    = 0;
    drop_cnt = 0;
    serr_cnt = 0;
    last_addr  = '0;
    first_addr = '0;
    reset           = 1'b1;
    pix_valid       = 1'b0;
    pix_frame_start = 1'b0;
    pix_data        = 6'd0;
    vga_vs          = 1'b1;
    model_reset();

    do_reset();
    check("rst_rd_bank", 32'(rd_bank), 32'd1);
    check("rst_waddr", 32'(fb_waddr), 32'd0);
    check("rst_we", 32'(fb_we), 32'd0);

    // full frame, back-to-back
    w_cnt = 0;
    send(F, 1'b1, 0);
    check("full_count", 32'(w_cnt), 32'(F));
    check("full_first", 32'(first_addr), 32'd0);
    check("full_last", 32'(last_addr), 32'(F - 1));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 6'd0, 1'b1);
    check("done_rd_keep", 32'(rd_bank), 32'd1);
    step(1'b0, 1'b0, 6'd0, 1'b0);
    check("swap_rd", 32'(rd_bank), 32'd0);
    step(1'b0, 1'b0, 6'd0, 1'b1);

    // gapped frame into bank 1
    w_cnt = 0;
    send(F, 1'b1, 1);
    check("gap_count", 32'(w_cnt), 32'(F));
    check("gap_first", 32'(first_addr), 32'h10000);
    check("gap_last", 32'(last_addr), 32'h10000 + 32'(F - 1));
    vsfall();
    check("swap2_rd", 32'(rd_bank), 32'd1);

    // early sof
    serr_cnt = 0;
    send(300, 1'b1, 2);
    send(1, 1'b1, 2);
    check("early_serr", 32'(serr_cnt), 32'd1);
    check("early_addr", 32'(last_addr), 32'd0);
    vsfall();
    check("early_noswap", 32'(rd_bank), 32'd1);
    send(F - 1, 1'b0, 2);
    check("early_last", 32'(last_addr), 32'(F - 1));
    check("early_serr2", 32'(serr_cnt), 32'd1);
    vsfall();
    check("early_swap", 32'(rd_bank), 32'd0);

    // dropped frame
    send(F, 1'b1, 0);
    drop_cnt = 0;
    w_cnt    = 0;
    send(F, 1'b1, 2);
    check("drop_pulse", 32'(drop_cnt), 32'd1);
    check("drop_nowrite", 32'(w_cnt), 32'd0);
    check("drop_rd", 32'(rd_bank), 32'd0);

    // sof on the same cycle as the vsync fall
    drop_cnt = 0;
    step(1'b0, 1'b0, 6'd0, 1'b1);
    step(1'b1, 1'b1, 6'h2a, 1'b0);
    check("simul_rd", 32'(rd_bank), 32'd1);
    check("simul_we", 32'(fb_we), 32'd1);
    check("simul_addr", 32'(fb_waddr), 32'd0);
    check("simul_drop", 32'(drop_cnt), 32'd0);
    step(1'b0, 1'b0, 6'd0, 1'b1);

    // reset mid-frame
    send(500, 1'b0, 2);
    do_reset();
    check("mid_rst_rd", 32'(rd_bank), 32'd1);
    check("mid_rst_we", 32'(fb_we), 32'd0);
    send(1, 1'b1, 0);
    check("mid_rst_addr", 32'(fb_waddr), 32'd0);
    check("mid_rst_we2", 32'(fb_we), 32'd1);

    // randomized soak with free-running vsync
    for (int i = 0; i < 6000; i++) begin
      step(1'($urandom_range(3) != 0),
           1'($urandom_range(1499) == 0),
           6'($urandom),
           1'((i % 700) >= 20));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
